// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter that shares one mem_ctrl command/data port between NUM_REQ requesters.
// One transaction in flight; mc_* fields are held from grant until the response is returned.
module mem_req_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int CMD_HOLD    = 2,
    parameter int WR_CYCLES   = 10,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      req_rdnwr,
    input  logic [NUM_REQ*16-1:0]   req_addr,
    input  logic [NUM_REQ*32-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      req_gnt,
    output logic [NUM_REQ-1:0]      rsp_vld,
    output logic [31:0]             rsp_rdata,
    output logic                    rsp_err,
    output logic                    mc_cmd_n,
    output logic                    mc_rdnwr,
    output logic [15:0]             mc_addr,
    output logic [31:0]             mc_data_in,
    output logic                    mc_data_in_vld,
    input  logic [31:0]             mc_data_out,
    input  logic                    mc_data_out_vld
);

    localparam int IW = (NUM_REQ > 2) ? 2 : 1;
    localparam logic [7:0] HOLD_LIM = 8'(CMD_HOLD);
    localparam logic [7:0] WR_LIM   = 8'(WR_CYCLES);
    localparam logic [7:0] TO_LIM   = 8'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_WR = 3'd2,
        S_WAIT_RD = 3'd3,
        S_RD_CAPT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]  owner_q, owner_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  rsp_vld_q, rsp_vld_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                cmd_n_q, cmd_n_d;
    logic                rdnwr_q, rdnwr_d;
    logic [15:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                din_vld_q, din_vld_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          wd_q, wd_d;

    logic [15:0]         addr_arr  [NUM_REQ];
    logic [31:0]         wdata_arr [NUM_REQ];

    logic                found;
    logic [IW-1:0]       win;
    logic [IW-1:0]       scan_idx;
    int                  scan_sum;
    logic [NUM_REQ-1:0]  win_oh;
    logic [IW-1:0]       rr_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign addr_arr[gi]  = req_addr[16*gi +: 16];
            assign wdata_arr[gi] = req_wdata[32*gi +: 32];
        end
    endgenerate

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Scan upward from rr_ptr, wrapping modulo NUM_REQ; first active request wins.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        scan_sum = 0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = int'(rr_ptr_q) + k;
            if (scan_sum >= NUM_REQ) begin
                scan_sum = scan_sum - NUM_REQ;
            end
            scan_idx = IW'(scan_sum);
            if (!found && req[scan_idx]) begin
                found = 1'b1;
                win   = scan_idx;
            end
        end
    end

    always_comb begin
        win_oh      = '0;
        win_oh[win] = 1'b1;
        rr_next     = (int'(win) == NUM_REQ - 1) ? '0 : win + IW'(1);
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        gnt_d       = '0;
        rsp_vld_d   = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cmd_n_d     = cmd_n_q;
        rdnwr_d     = rdnwr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        din_vld_d   = din_vld_q;
        cnt_d       = cnt_q;
        wd_d        = wd_q;

        case (state_q)
            S_IDLE: begin
                cmd_n_d = 1'b1;
                if (found) begin
                    state_d   = S_ISSUE;
                    gnt_d     = win_oh;
                    owner_d   = win_oh;
                    rr_ptr_d  = rr_next;
                    rdnwr_d   = req_rdnwr[win];
                    addr_d    = addr_arr[win];
                    wdata_d   = wdata_arr[win];
                    cmd_n_d   = 1'b0;
                    din_vld_d = ~req_rdnwr[win];
                    cnt_d     = 8'd1;
                    wd_d      = 8'd0;
                end
            end

            // cnt_q holds the 1-based cycle number since ISSUE entry.
            S_ISSUE: begin
                cnt_d = sat_inc(cnt_q);
                if (!rdnwr_q && cnt_q >= WR_LIM) begin
                    din_vld_d = 1'b0;
                end
                if (cnt_q >= HOLD_LIM) begin
                    cmd_n_d = 1'b1;
                    if (rdnwr_q) begin
                        state_d = S_WAIT_RD;
                        wd_d    = 8'd1;
                    end else if (cnt_q >= WR_LIM) begin
                        state_d     = S_IDLE;
                        rsp_vld_d   = owner_q;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = '0;
                        din_vld_d   = 1'b0;
                    end else begin
                        state_d = S_WAIT_WR;
                    end
                end
            end

            S_WAIT_WR: begin
                cnt_d = sat_inc(cnt_q);
                if (cnt_q >= WR_LIM) begin
                    state_d     = S_IDLE;
                    rsp_vld_d   = owner_q;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                    din_vld_d   = 1'b0;
                end
            end

            // Data beats the watchdog when both land in the same cycle.
            S_WAIT_RD: begin
                if (mc_data_out_vld) begin
                    state_d = S_RD_CAPT;
                end else if (wd_q >= TO_LIM) begin
                    state_d     = S_IDLE;
                    rsp_vld_d   = owner_q;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    wd_d = sat_inc(wd_q);
                end
            end

            S_RD_CAPT: begin
                state_d     = S_IDLE;
                rsp_vld_d   = owner_q;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = mc_data_out;
            end

            default: begin
                state_d = S_IDLE;
                cmd_n_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            gnt_q       <= '0;
            rsp_vld_q   <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cmd_n_q     <= 1'b1;
            rdnwr_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            din_vld_q   <= 1'b0;
            cnt_q       <= '0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cmd_n_q     <= cmd_n_d;
            rdnwr_q     <= rdnwr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            din_vld_q   <= din_vld_d;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
        end
    end

    assign req_gnt        = gnt_q;
    assign rsp_vld        = rsp_vld_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_err        = rsp_err_q;
    assign mc_cmd_n       = cmd_n_q;
    assign mc_rdnwr       = rdnwr_q;
    assign mc_addr        = addr_q;
    assign mc_data_in     = wdata_q;
    assign mc_data_in_vld = din_vld_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: expected responses are queued at request time
// and popped when rsp_vld is observed; timing and hold properties are checked per transaction.
module tb_mem_req_arbiter;

    localparam int NUM_REQ     = 2;
    localparam int CMD_HOLD    = 2;
    localparam int WR_CYCLES   = 10;
    localparam int TIMEOUT_CYC = 64;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [NUM_REQ-1:0]     req = '0;
    logic [NUM_REQ-1:0]     req_rdnwr = '0;
    logic [NUM_REQ*16-1:0]  req_addr = '0;
    logic [NUM_REQ*32-1:0]  req_wdata = '0;
    logic [NUM_REQ-1:0]     req_gnt;
    logic [NUM_REQ-1:0]     rsp_vld;
    logic [31:0]            rsp_rdata;
    logic                   rsp_err;
    logic                   mc_cmd_n;
    logic                   mc_rdnwr;
    logic [15:0]            mc_addr;
    logic [31:0]            mc_data_in;
    logic                   mc_data_in_vld;
    logic [31:0]            mc_data_out = '0;
    logic                   mc_data_out_vld = 1'b0;

    mem_req_arbiter #(
        .NUM_REQ(NUM_REQ), .CMD_HOLD(CMD_HOLD),
        .WR_CYCLES(WR_CYCLES), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_rdnwr(req_rdnwr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_gnt(req_gnt),
        .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mc_cmd_n(mc_cmd_n), .mc_rdnwr(mc_rdnwr), .mc_addr(mc_addr),
        .mc_data_in(mc_data_in), .mc_data_in_vld(mc_data_in_vld),
        .mc_data_out(mc_data_out), .mc_data_out_vld(mc_data_out_vld)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_REQ-1:0] vld;
        logic [31:0]        rdata;
        logic               err;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Cycle 1 is the grant cycle (ISSUE entry); returns the cycle rsp_vld should appear.
    function automatic int exp_latency(input logic rd, input int vld_at);
        if (!rd) return WR_CYCLES + 1;
        if (vld_at >= CMD_HOLD + 1 && vld_at <= CMD_HOLD + TIMEOUT_CYC) return vld_at + 2;
        return CMD_HOLD + TIMEOUT_CYC + 1;
    endfunction

    task automatic do_txn(input int who, input logic rd, input logic [15:0] addr,
                          input logic [31:0] wd, input int vld_at, input logic [31:0] rdat,
                          input bit keep_req);
        exp_t e;
        exp_t got_e;
        int   lat, cmd_low, din_hi, unstable, bad_gnt, rsp_c;
        bit   got, in_win;
        lat    = exp_latency(rd, vld_at);
        in_win = rd && (vld_at >= CMD_HOLD + 1) && (vld_at <= CMD_HOLD + TIMEOUT_CYC);
        e.vld      = '0;
        e.vld[who] = 1'b1;
        e.err      = rd && !in_win;
        e.rdata    = in_win ? rdat : 32'h0;
        sb.push_back(e);

        req[who]                = 1'b1;
        req_rdnwr[who]          = rd;
        req_addr[16*who +: 16]  = addr;
        req_wdata[32*who +: 32] = wd;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_gnt !== '0) begin
                got = 1'b1;
                break;
            end
        end
        check($sformatf("grant_r%0d", who), 64'(req_gnt), 64'(e.vld));
        if (!got) begin
            req[who] = 1'b0;
            void'(sb.pop_back());
            return;
        end
        if (!keep_req) req[who] = 1'b0;

        cmd_low = 0; din_hi = 0; unstable = 0; bad_gnt = 0; rsp_c = 0;
        for (int c = 1; c <= lat + 10; c++) begin
            if (c > 1) @(negedge clk);
            if (!mc_cmd_n) cmd_low++;
            if (mc_data_in_vld) din_hi++;
            if (mc_addr !== addr || mc_rdnwr !== rd || mc_data_in !== wd) unstable++;
            if (c > 1 && req_gnt !== '0) bad_gnt++;
            if (rsp_vld !== '0) begin
                rsp_c = c;
                break;
            end
            mc_data_out_vld = (c == vld_at);
            mc_data_out     = (c == vld_at + 1) ? rdat : $urandom;
        end
        mc_data_out_vld = 1'b0;

        check("rsp_cycle", 64'(rsp_c), 64'(lat));
        if (sb.size() > 0) begin
            got_e = sb.pop_front();
            check("rsp_vld", 64'(rsp_vld), 64'(got_e.vld));
            check("rsp_rdata", 64'(rsp_rdata), 64'(got_e.rdata));
            check("rsp_err", 64'(rsp_err), 64'(got_e.err));
        end
        check("cmd_low_cycles", 64'(cmd_low), 64'(CMD_HOLD));
        check("din_vld_cycles", 64'(din_hi), rd ? 64'd0 : 64'(WR_CYCLES));
        check("mc_fields_stable", 64'(unstable), 64'd0);
        check("no_gnt_in_txn", 64'(bad_gnt), 64'd0);
        $display("txn r%0d %s addr=%h lat=%0d rsp_at=%0d err=%0b rdata=%h",
                 who, rd ? "RD" : "WR", addr, lat, rsp_c, rsp_err, rsp_rdata);
    endtask

    initial begin
        int n_bad;
        bit got;

        // Reset values
        #1 rst = 1'b1;
        #2;
        check("rst_cmd_n", 64'(mc_cmd_n), 64'd1);
        check("rst_gnt", 64'(req_gnt), 64'd0);
        check("rst_rsp_vld", 64'(rsp_vld), 64'd0);
        check("rst_addr", 64'(mc_addr), 64'd0);
        check("rst_din_vld", 64'(mc_data_in_vld), 64'd0);
        check("rst_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_err", 64'(rsp_err), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_txn(0, 1'b1, 16'h3005, 32'h0000_0000, 9, 32'hDEAD_BEEF, 1'b0);
        // mc_data_out_vld pulsed during ISSUE of a write must be ignored
        do_txn(1, 1'b0, 16'h1010, 32'hA5A5_A5A5, 2, 32'h1111_2222, 1'b0);
        do_txn(0, 1'b1, 16'h2222, 32'h5555_0000, 0, 32'h0, 1'b0);
        do_txn(1, 1'b1, 16'h4321, 32'h0, 5, 32'h1234_5678, 1'b0);
        do_txn(0, 1'b1, 16'h7ABC, 32'h0, CMD_HOLD + TIMEOUT_CYC, 32'hCAFE_F00D, 1'b0);

        // Reset four cycles into a write by requester 1
        req[1] = 1'b1; req_rdnwr[1] = 1'b0;
        req_addr[31:16] = 16'h0BEE; req_wdata[63:32] = 32'h0F0F_0F0F;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_gnt !== '0) begin got = 1'b1; break; end
        end
        check("midrst_grant", 64'(req_gnt), 64'b10);
        req[1] = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_cmd_n", 64'(mc_cmd_n), 64'd1);
        check("midrst_din_vld", 64'(mc_data_in_vld), 64'd0);
        check("midrst_addr", 64'(mc_addr), 64'd0);
        check("midrst_data_in", 64'(mc_data_in), 64'd0);
        check("midrst_rdnwr", 64'(mc_rdnwr), 64'd0);
        n_bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_vld !== '0 || req_gnt !== '0) n_bad++;
            if (i == 2) rst = 1'b0;
        end
        check("midrst_no_rsp", 64'(n_bad), 64'd0);
        $display("txn midreset abandon got_gnt=%0b spurious=%0d", got, n_bad);

        // Fairness: both requesters held high, rr_ptr restarted at 0
        req[1] = 1'b1; req_rdnwr[1] = 1'b1; req_addr[31:16] = 16'h00B1;
        do_txn(0, 1'b1, 16'h00A0, 32'h0, 3, 32'hA000_0001, 1'b1);
        do_txn(1, 1'b1, 16'h00B1, 32'h0, 4, 32'hB000_0002, 1'b1);
        do_txn(0, 1'b1, 16'h00A0, 32'h0, 5, 32'hA000_0003, 1'b1);
        do_txn(1, 1'b1, 16'h00B1, 32'h0, 3, 32'hB000_0004, 1'b1);
        req = '0;

        // Same address from both requesters: served in round-robin order
        req[1] = 1'b1; req_rdnwr[1] = 1'b0;
        req_addr[31:16] = 16'h5A5A; req_wdata[63:32] = 32'h2222_2222;
        do_txn(0, 1'b0, 16'h5A5A, 32'h1111_1111, 0, 32'h0, 1'b0);
        do_txn(1, 1'b0, 16'h5A5A, 32'h2222_2222, 0, 32'h0, 1'b0);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares the single mem_ctrl command/data port between NUM_REQ requesters.
- Round-robin arbitration; one transaction outstanding at a time.
- Drives mem_ctrl's cmd_n / RDnWR / Addr_in / Data_in / Data_in_vld and holds them stable for the whole transaction.
- Waits for read data (data_out_vld) or a fixed write window, then returns a per-requester response; a watchdog aborts hung transactions.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- CMD_HOLD, 2, cycles mc_cmd_n is held low per transaction (1..15).
- WR_CYCLES, 10, cycles Data_in_vld is held for a write before completion (1..255).
- TIMEOUT_CYC, 64, watchdog limit in cycles for a read awaiting mc_data_out_vld (2..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level.
- req_rdnwr  in  NUM_REQ  1 = read, 0 = write.
- req_addr  in  NUM_REQ*16  per-requester address {row[15:12], col[11:0]}; requester i uses slice [16i+15:16i].
- req_wdata  in  NUM_REQ*32  per-requester write data; slice [32i+31:32i].
- req_gnt  out  NUM_REQ  one-cycle accept pulse, one-hot.
- rsp_vld  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  32  read data, valid with rsp_vld.
- rsp_err  out  1  timeout flag, valid with rsp_vld.
- mc_cmd_n  out  1  to mem_ctrl cmd_n, active low.
- mc_rdnwr  out  1  to mem_ctrl RDnWR.
- mc_addr  out  16  to mem_ctrl Addr_in.
- mc_data_in  out  32  to mem_ctrl Data_in.
- mc_data_in_vld  out  1  to mem_ctrl Data_in_vld.
- mc_data_out  in  32  from mem_ctrl Data_out.
- mc_data_out_vld  in  1  from mem_ctrl data_out_vld.

Behaviour:
- Reset (async, rst=1):
  - state = IDLE, rr_ptr = 0.
  - mc_cmd_n = 1.
  - mc_rdnwr, mc_addr, mc_data_in, mc_data_in_vld = 0.
  - req_gnt, rsp_vld, rsp_rdata, rsp_err = 0.
  - All counters = 0.
- Reset mid-transaction abandons the transaction with no rsp_vld. The requester reissues.
- Request handshake:
  - A requester holds req and its payload until it sees req_gnt.
  - The arbiter captures the payload on the gnt cycle; the requester may drop req the next cycle.
- Arbitration (IDLE only):
  - Scan starts at rr_ptr and proceeds upward modulo NUM_REQ; the first requester with req=1 wins.
  - Winner w gets req_gnt[w]=1 for one cycle, its payload registers into mc_* outputs, and rr_ptr = (w+1) mod NUM_REQ, which wraps from NUM_REQ-1 to 0.
  - Next state is ISSUE.
  - No req: stay in IDLE, outputs unchanged except mc_cmd_n = 1.
- ISSUE:
  - mc_cmd_n = 0 for exactly CMD_HOLD cycles, counted from entry, then mc_cmd_n returns to 1.
  - Write: mc_data_in_vld = 1 from ISSUE entry. After CMD_HOLD cycles, go to WAIT_WR.
  - Read: after CMD_HOLD cycles, go to WAIT_RD.
- mc_addr, mc_rdnwr and mc_data_in are held constant from the grant until return to IDLE.
- WAIT_WR:
  - mc_data_in_vld stays 1 until WR_CYCLES total cycles have elapsed since ISSUE entry.
  - On the following cycle: rsp_vld[w]=1, rsp_err=0, rsp_rdata=0, mc_data_in_vld=0, next state IDLE.
- WAIT_RD:
  - On mc_data_out_vld=1, go to RD_CAPT. mem_ctrl registers Data_out one cycle after its vld.
  - The watchdog counts cycles in WAIT_RD. On reaching TIMEOUT_CYC: rsp_vld[w]=1, rsp_err=1, rsp_rdata=0, next state IDLE.
- RD_CAPT (one cycle): rsp_rdata <= mc_data_out, rsp_vld[w]=1, rsp_err=0, next state IDLE.
- rsp_vld and req_gnt are never asserted in the same cycle.
- A new grant is issued at the earliest on the cycle after rsp_vld.
- mc_data_out_vld seen outside WAIT_RD is ignored.
- If mc_data_out_vld and the timeout fall in the same cycle, data wins: go to RD_CAPT, no error.
- req with the same address from two requesters is serviced in round-robin order. No merging, no reordering.
- Counters are 8-bit saturating at their limit; there is no wrap-around inside a transaction.

Test Plan:
- Single read: NUM_REQ=2, reset, req[0]=1 read addr 16'h3005, mc_data_out_vld pulsed 8 cycles after ISSUE with mc_data_out=32'hDEADBEEF on the next cycle -> req_gnt=2'b01 one cycle; mc_cmd_n low exactly 2 cycles; mc_addr=16'h3005 stable throughout; rsp_vld=2'b01 with rsp_rdata=32'hDEADBEEF, rsp_err=0.
- Single write: req[1]=1 write addr 16'h1010 data 32'hA5A5A5A5 -> mc_data_in_vld high exactly 10 cycles; mc_data_in=32'hA5A5A5A5 stable; rsp_vld=2'b10 on the 11th cycle after ISSUE entry.
- Fairness: req=2'b11 held continuously, all reads -> grants alternate 01,10,01,10; first grant goes to requester 0 after reset; never two consecutive grants to one requester.
- Timeout: read with mc_data_out_vld never asserted -> rsp_vld after exactly 64 cycles in WAIT_RD, rsp_err=1, rsp_rdata=0; next request is granted normally.
- Reset mid-WAIT_WR: assert rst 4 cycles into a write -> all outputs at reset values immediately (async); no rsp_vld; after release req[1] is granted first only if req[0]=0 (rr_ptr=0).
- Data/timeout collision: mc_data_out_vld arrives on the 64th WAIT_RD cycle -> RD_CAPT path taken; rsp_err=0 with captured data.
